// File: rtl/ram_pkg.sv
// Shared definitions for the single-port byte-enable RAM.
// Read-during-write modes, clear FSM states and lane helper.
package ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    typedef enum logic {
        CLEAR,
        IDLE
    } clr_state_t;

    function automatic int lane_count(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset clear engine: walks every word address once,
// then releases the array to user traffic.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int Addr_width     = 7,
    parameter int Clear_on_reset = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    output logic                  clr_we,
    output logic [Addr_width-1:0] clr_addr
);

    localparam clr_state_t RstState = (Clear_on_reset != 0) ? CLEAR : IDLE;

    clr_state_t            state;
    clr_state_t            state_nxt;
    logic [Addr_width-1:0] cnt;
    logic [Addr_width-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RstState;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        unique case (state)
            CLEAR: begin
                clr_we  = 1'b1;
                cnt_nxt = cnt + Addr_width'(1);
                if (cnt == '1) state_nxt = IDLE;
            end
            IDLE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/ram_sp_be_init.sv
// Single-port synchronous RAM with byte enables, selectable
// read-during-write behaviour, optional output register and clear.
module ram_sp_be_init
    import ram_pkg::*;
#(
    parameter int Data_width     = 32,
    parameter int Addr_width     = 7,
    parameter int Byte_width     = 8,
    parameter int Rdw_mode       = 0,
    parameter int Out_reg        = 0,
    parameter int Clear_on_reset = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             we,
    input  logic [Data_width/Byte_width-1:0] be,
    input  logic [Addr_width-1:0]            address,
    input  logic [Data_width-1:0]            d,
    output logic [Data_width-1:0]            q,
    output logic                             q_valid,
    output logic                             busy
);

    localparam int Lanes      = lane_count(Data_width, Byte_width);
    localparam int Depth      = 2 ** Addr_width;
    localparam bit WriteFirst = (Rdw_mode == RDW_WRITE_FIRST);
    localparam bit NoChange   = (Rdw_mode == RDW_NO_CHANGE);

    if (Data_width % Byte_width != 0) begin : g_bad_width
        $error("Data_width must be a multiple of Byte_width");
    end

    logic [Data_width-1:0] mem [Depth];
    logic                  clr_we;
    logic [Addr_width-1:0] clr_addr;
    logic                  acc;
    logic                  rd_fire;
    logic [Data_width-1:0] old_word;
    logic [Data_width-1:0] merged;
    logic [Data_width-1:0] rd_word;
    logic                  s1_valid;
    logic [Data_width-1:0] s1_data;

    ram_clear_ctrl #(
        .Addr_width     (Addr_width),
        .Clear_on_reset (Clear_on_reset)
    ) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign acc      = en & ~busy;
    assign old_word = mem[address];

    always_comb begin
        merged = old_word;
        for (int i = 0; i < Lanes; i++) begin
            if (be[i]) merged[i*Byte_width +: Byte_width] = d[i*Byte_width +: Byte_width];
        end
    end

    // No-change mode suppresses the read side of a write entirely
    assign rd_fire = acc & (~we | ~NoChange);
    assign rd_word = (we & WriteFirst) ? merged : old_word;

    // Clear engine owns the write port while busy
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (acc & we) begin
            mem[address] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) s1_data <= rd_word;
        end
    end

    if (Out_reg != 0) begin : g_oreg
        logic [Data_width-1:0] q_r;
        logic                  v_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_r <= '0;
                v_r <= 1'b0;
            end else begin
                v_r <= s1_valid;
                if (s1_valid) q_r <= s1_data;
            end
        end

        assign q       = q_r;
        assign q_valid = v_r;
    end else begin : g_noreg
        assign q       = s1_data;
        assign q_valid = s1_valid;
    end

endmodule

// File: tb/tb_ram_sp_be_init.sv
// Bench for ram_sp_be_init: four clearing variants share stimulus
// against a reference model; a fifth variant has no clear.
module tb_ram_sp_be_init;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [6:0]  address;
    logic [31:0] d;
    logic [31:0] q_o [4];
    logic        qv_o [4];
    logic        busy_o [4];

    logic        en_e;
    logic        we_e;
    logic [3:0]  be_e;
    logic [6:0]  addr_e;
    logic [31:0] d_e;
    logic [31:0] q_e;
    logic        qv_e;
    logic        busy_e;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_sp_be_init #(.Rdw_mode(0), .Out_reg(0), .Clear_on_reset(1)) dut_rf (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .address(address),
        .d(d), .q(q_o[0]), .q_valid(qv_o[0]), .busy(busy_o[0]));
    ram_sp_be_init #(.Rdw_mode(1), .Out_reg(0), .Clear_on_reset(1)) dut_wf (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .address(address),
        .d(d), .q(q_o[1]), .q_valid(qv_o[1]), .busy(busy_o[1]));
    ram_sp_be_init #(.Rdw_mode(2), .Out_reg(0), .Clear_on_reset(1)) dut_nc (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .address(address),
        .d(d), .q(q_o[2]), .q_valid(qv_o[2]), .busy(busy_o[2]));
    ram_sp_be_init #(.Rdw_mode(0), .Out_reg(1), .Clear_on_reset(1)) dut_or (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .address(address),
        .d(d), .q(q_o[3]), .q_valid(qv_o[3]), .busy(busy_o[3]));
    ram_sp_be_init #(.Rdw_mode(0), .Out_reg(0), .Clear_on_reset(0)) dut_ncl (
        .clk(clk), .rst_n(rst_n), .en(en_e), .we(we_e), .be(be_e), .address(addr_e),
        .d(d_e), .q(q_e), .q_valid(qv_e), .busy(busy_e));

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    // Reference model: memory image, expected outputs per variant
    logic [31:0] mem_m [128] = '{default: '0};
    logic [31:0] exp_q [4]   = '{default: '0};
    logic        exp_v [4]   = '{default: 1'b0};
    logic        busy_m      = 1'b1;
    int          cyc         = 0;
    logic        pv          = 1'b0;
    logic [31:0] pq          = '0;
    logic        m_acc;
    logic [31:0] m_old;
    logic [31:0] m_new;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_m = 1'b1;
            cyc    = 0;
            pv     = 1'b0;
            pq     = '0;
            for (int k = 0; k < 4; k++) begin
                exp_q[k] = '0;
                exp_v[k] = 1'b0;
            end
        end else begin
            m_acc = en && !busy_m;
            m_old = mem_m[address];
            m_new = m_old;
            for (int l = 0; l < 4; l++)
                if (be[l]) m_new[l*8 +: 8] = d[l*8 +: 8];
            for (int r = 0; r < 3; r++) begin
                if (m_acc && !(we && r == 2)) begin
                    exp_q[r] = (we && r == 1) ? m_new : m_old;
                    exp_v[r] = 1'b1;
                end else begin
                    exp_v[r] = 1'b0;
                end
            end
            exp_v[3] = pv;
            if (pv) exp_q[3] = pq;
            pv = m_acc;
            if (m_acc) pq = m_old;
            if (m_acc && we) mem_m[address] = m_new;
            if (busy_m) begin
                cyc++;
                if (cyc == 128) begin
                    busy_m = 1'b0;
                    for (int i = 0; i < 128; i++) mem_m[i] = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            check("q", k, q_o[k], exp_q[k]);
            check("q_valid", k, {31'b0, qv_o[k]}, {31'b0, exp_v[k]});
            check("busy", k, {31'b0, busy_o[k]}, {31'b0, busy_m});
        end
        check("busy_noclear", 4, {31'b0, busy_e}, 32'd0);
    end

    typedef struct {
        logic        en;
        logic        we;
        logic [3:0]  be;
        logic [6:0]  addr;
        logic [31:0] d;
        logic [31:0] qa;
        logic        va;
        logic [31:0] qb;
        logic [31:0] qc;
        logic        vc;
        logic [31:0] qd;
        logic        vd;
    } vec_t;

    vec_t tbl [15];
    int   cnt;

    task automatic busy_window(input string name);
        cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            cnt = i;
            #1;
            if (!busy_o[0]) break;
            we      = 1'($urandom);
            address = 7'($urandom);
            d       = $urandom;
            be      = 4'($urandom);
        end
        check(name, 0, cnt, 128);
    endtask

    initial begin
        tbl[0]  = '{1, 0, 4'hF, 7'h7F, 32'h0, 32'h0, 1, 32'h0, 32'h0, 1, 32'h0, 0};
        tbl[1]  = '{1, 1, 4'hF, 7'h05, 32'hDEADBEEF, 32'h0, 1, 32'hDEADBEEF, 32'h0, 0, 32'h0, 1};
        tbl[2]  = '{1, 1, 4'h5, 7'h05, 32'h11223344, 32'hDEADBEEF, 1, 32'hDE22BE44, 32'h0, 0, 32'h0, 1};
        tbl[3]  = '{1, 0, 4'hF, 7'h05, 32'h0, 32'hDE22BE44, 1, 32'hDE22BE44, 32'hDE22BE44, 1, 32'hDEADBEEF, 1};
        tbl[4]  = '{1, 1, 4'hF, 7'h09, 32'hAAAA5555, 32'h0, 1, 32'hAAAA5555, 32'hDE22BE44, 0, 32'hDE22BE44, 1};
        tbl[5]  = '{1, 1, 4'hF, 7'h09, 32'h12345678, 32'hAAAA5555, 1, 32'h12345678, 32'hDE22BE44, 0, 32'h0, 1};
        tbl[6]  = '{1, 1, 4'hF, 7'h01, 32'h1, 32'h0, 1, 32'h1, 32'hDE22BE44, 0, 32'hAAAA5555, 1};
        tbl[7]  = '{1, 1, 4'hF, 7'h02, 32'h2, 32'h0, 1, 32'h2, 32'hDE22BE44, 0, 32'h0, 1};
        tbl[8]  = '{1, 1, 4'hF, 7'h03, 32'h3, 32'h0, 1, 32'h3, 32'hDE22BE44, 0, 32'h0, 1};
        tbl[9]  = '{1, 1, 4'h0, 7'h05, 32'hFFFFFFFF, 32'hDE22BE44, 1, 32'hDE22BE44, 32'hDE22BE44, 0, 32'h0, 1};
        tbl[10] = '{1, 0, 4'hF, 7'h01, 32'h0, 32'h1, 1, 32'h1, 32'h1, 1, 32'hDE22BE44, 1};
        tbl[11] = '{1, 0, 4'hF, 7'h02, 32'h0, 32'h2, 1, 32'h2, 32'h2, 1, 32'h1, 1};
        tbl[12] = '{1, 0, 4'hF, 7'h03, 32'h0, 32'h3, 1, 32'h3, 32'h3, 1, 32'h2, 1};
        tbl[13] = '{0, 0, 4'h0, 7'h00, 32'h0, 32'h3, 0, 32'h3, 32'h3, 0, 32'h3, 1};
        tbl[14] = '{0, 0, 4'h0, 7'h00, 32'h0, 32'h3, 0, 32'h3, 32'h3, 0, 32'h3, 0};

        rst_n = 1'b0; en = 1'b0; we = 1'b0; be = '0; address = '0; d = '0;
        en_e = 1'b0; we_e = 1'b0; be_e = '0; addr_e = '0; d_e = '0;
        repeat (3) @(negedge clk);

        en = 1'b1;
        en_e = 1'b1; we_e = 1'b1; be_e = 4'hF; addr_e = 7'd3; d_e = 32'hA5A50F0F;
        #2 rst_n = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            cnt = i;
            #1;
            if (i == 1) we_e = 1'b0;
            if (i == 2) begin
                check("noclear_rd", 0, q_e, 32'hA5A50F0F);
                check("noclear_rv", 0, {31'b0, qv_e}, 32'd1);
                we_e = 1'b1; be_e = 4'h3; d_e = 32'h12345678;
            end
            if (i == 3) we_e = 1'b0;
            if (i == 4) begin
                check("noclear_rd", 1, q_e, 32'hA5A55678);
                check("noclear_rv", 1, {31'b0, qv_e}, 32'd1);
                en_e = 1'b0;
            end
            if (!busy_o[0]) break;
            we      = 1'($urandom);
            address = 7'($urandom);
            d       = $urandom;
            be      = 4'($urandom);
        end
        check("busy_len", 0, cnt, 128);
        en = 1'b0;

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            en = tbl[i].en; we = tbl[i].we; be = tbl[i].be;
            address = tbl[i].addr; d = tbl[i].d;
            @(negedge clk);
            check("tbl_qa", i, q_o[0], tbl[i].qa);
            check("tbl_va", i, {31'b0, qv_o[0]}, {31'b0, tbl[i].va});
            check("tbl_qb", i, q_o[1], tbl[i].qb);
            check("tbl_vb", i, {31'b0, qv_o[1]}, {31'b0, tbl[i].va});
            check("tbl_qc", i, q_o[2], tbl[i].qc);
            check("tbl_vc", i, {31'b0, qv_o[2]}, {31'b0, tbl[i].vc});
            check("tbl_qd", i, q_o[3], tbl[i].qd);
            check("tbl_vd", i, {31'b0, qv_o[3]}, {31'b0, tbl[i].vd});
        end

        for (int n = 0; n < 400; n++) begin
            en      = ($urandom_range(0, 3) != 0);
            we      = 1'($urandom_range(0, 1));
            be      = 4'($urandom);
            address = 7'($urandom_range(0, 15));
            d       = $urandom;
            @(negedge clk);
        end

        en = 1'b1; we = 1'b1; be = 4'hF; address = 7'd7; d = 32'hCAFEF00D;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        check("cafe_rd", 0, q_o[0], 32'hCAFEF00D);
        en = 1'b0;

        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        en = 1'b1;
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_q", 0, q_o[0], 32'h0);
        check("rst_v", 0, {31'b0, qv_o[0]}, 32'd0);
        check("rst_q", 3, q_o[3], 32'h0);
        #2 rst_n = 1'b1;
        busy_window("busy_len_rst");
        en = 1'b0;

        @(negedge clk);
        en = 1'b1; we = 1'b0; be = 4'hF; address = 7'd7;
        @(negedge clk);
        check("cleared_rd", 0, q_o[0], 32'h0);
        check("cleared_rv", 0, {31'b0, qv_o[0]}, 32'd1);
        en = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_sp_be_init.md
Name: ram_sp_be_init

Overview:
Parametrised single-port synchronous RAM, successor to the fixed 128x32 store.
- Adds per-byte write enables and an access enable.
- Selectable read-during-write behaviour and an optional output pipeline register.
- Built-in post-reset clear engine that zeroes the array before accepting traffic.
- Used as the common on-chip scratch/buffer memory behind datapath blocks.

Parameters:
Data_width, 32, bits per word; must be a multiple of Byte_width (elaboration error otherwise)
Addr_width, 7, address bits; depth = 2**Addr_width words
Byte_width, 8, bits per write-enable lane
Rdw_mode, 0, read-during-write: 0 = read-first (old data), 1 = write-first (merged new data), 2 = no-change (q holds)
Out_reg, 0, 0 = read latency 1; 1 = extra output register, latency 2
Clear_on_reset, 1, 1 = zero every word after reset; 0 = no clear, contents undefined after power-up

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  access request; ignored while busy=1
we  input  1  1 = write, 0 = read (qualified by en)
be  input  Data_width/Byte_width  byte-lane write enables; lane i covers bits [i*Byte_width +: Byte_width]
address  input  Addr_width  word address
d  input  Data_width  write data
q  output  Data_width  read data; holds its value between accesses
q_valid  output  1  one-cycle pulse when q carries new data
busy  output  1  clear engine active; accesses are dropped

Behaviour:
- Reset values (async on rst_n=0): q=0, q_valid=0, output pipeline stage=0, clear counter=0, busy=Clear_on_reset. Array contents are not touched by reset itself.
- Clear FSM, states CLEAR and IDLE. Reset enters CLEAR if Clear_on_reset=1, else IDLE.
  - CLEAR writes 0 to word [counter] each cycle, then increments the counter.
  - After writing word 2**Addr_width-1, the FSM moves to IDLE on the next edge. busy falls exactly 2**Addr_width cycles after rst_n deasserts.
  - rst_n asserted mid-clear restarts at counter 0.
  - en is ignored in CLEAR: no write, no q update, no q_valid.
- Accept condition = en & !busy.
- Write (accepted, we=1): each lane with be[i]=1 takes d's lane i. Lanes with be=0 keep their old contents. be=0 writes nothing but still counts as an access for q/q_valid.
- Read (accepted, we=0): q <= mem[address]; q_valid pulses.
- Write with Rdw_mode:
  - 0: q <= pre-write word, q_valid pulses.
  - 1: q <= merged word (new lanes where be=1, old elsewhere), q_valid pulses.
  - 2: q unchanged, no q_valid.
- Latency:
  - Out_reg=0: q/q_valid update on the edge after the accepting edge.
  - Out_reg=1: q/q_valid appear one cycle later. The pipeline register takes only qualified data and keeps full throughput (one access per cycle, back-to-back).
- No access: q holds and q_valid=0.
- Consecutive accesses to the same address see each other's writes in program order. There is no bypass hazard because there is a single port.

Decomposition:
- Shared package ram_pkg holds:
  - RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, RDW_NO_CHANGE=2 constants.
  - Clear FSM state enum (CLEAR, IDLE).
  - Helper function for lane count (Data_width/Byte_width).
- One sub-module, ram_clear_ctrl: holds the counter and FSM. Outputs busy, clr_we and clr_addr, which the top muxes onto the array write port ahead of user traffic.

Test Plan:
- Default params, release rst_n, hold en=1 throughout -> busy=1 for exactly 128 cycles, no q_valid. Then read address 0x7F -> q=0x00000000 with q_valid one cycle later.
- Write address 5, d=0xDEADBEEF, be=4'b1111. Then write address 5, d=0x11223344, be=4'b0101. Read address 5 -> q=0xDE22BE44.
- Rdw_mode=0, address 9 holds 0xAAAA5555. Write d=0x12345678, be=4'hF -> q=0xAAAA5555. With Rdw_mode=1 -> q=0x12345678. With Rdw_mode=2 -> q holds the prior value and q_valid=0.
- Out_reg=1: back-to-back reads of addresses 1,2,3 holding 0x1,0x2,0x3 -> q_valid high on cycles +2,+3,+4 with q=0x1,0x2,0x3.
- Write 0xCAFEF00D to address 7 after clear. Assert rst_n=0 after 40 clear cycles of a second reset, then release -> busy lasts a full 128 cycles from the second release. Address 7 reads 0x00000000 afterwards. q=0 and q_valid=0 during reset.
- Clear_on_reset=0 -> busy=0 immediately after reset. A write at the first cycle after release is accepted, and readback matches.
